// File: rtl/sincos_pkg.sv
// Shared types and constants for the CORDIC phase detector.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package sincos_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // 1/K for the accumulated CORDIC gain K ~= 1.64676, as a Q16 fraction
    localparam int unsigned CORDIC_GAIN_INV_Q16 = 39797;

    localparam real PI = 3.14159265358979323846;

    // Scaled arctangent of 2^-i, expressed as a fraction of a full turn in outputBits
    function automatic int unsigned atan_entry(input int i, input int outputBits);
        real angle;
        real scaled;
        angle  = $atan(1.0 / (2.0 ** i));
        scaled = angle / (2.0 * PI) * (2.0 ** outputBits);
        return $unsigned($rtoi(scaled + 0.5));
    endfunction

    // Phase code for pi (half a turn)
    function automatic int unsigned PHASE_HALF_TURN(input int outputBits);
        return 32'd1 << (outputBits - 1);
    endfunction

endpackage

// File: rtl/sincos_atan_rom.sv
// Constant arctangent table, one entry per CORDIC micro-rotation.
// Latency: combinational read.
// Backpressure: none; addressed every cycle by the iteration counter.
module sincos_atan_rom
    import sincos_pkg::*;
#(
    parameter int iterations = 16,
    parameter int outputBits = 16,
    parameter int addrBits   = 4
) (
    input  logic [addrBits-1:0]   addr,
    output logic [outputBits-1:0] atanVal
);

    logic [outputBits-1:0] romTable [iterations];

    for (genvar g = 0; g < iterations; g++) begin : gEntry
        localparam logic [outputBits-1:0] ENTRY = outputBits'(atan_entry(g, outputBits));
        assign romTable[g] = ENTRY;
    end

    // Addresses past the last micro-rotation never occur; return 0 to keep the read defined
    always_comb begin
        atanVal = '0;
        if (int'(addr) < iterations) begin
            atanVal = romTable[addr];
        end
    end

endmodule

// File: rtl/sincos_phase_detector.sv
// Recovers atan2(sin, cos) as an unsigned turn fraction with an iterative CORDIC; optional magnitude via SINCOS_MAGNITUDE_EN.
// Latency: iterations+1 cycles from accept edge to the one-cycle outValid pulse; one sample per iterations+2 cycles.
// Backpressure: inReady is high only in IDLE; inValid while busy is ignored (no queueing), the source must hold it.
module sincos_phase_detector
    import sincos_pkg::*;
#(
    parameter int inputBits    = 16,
    parameter int outputBits   = 16,
    parameter int iterations   = 16,
    parameter int offsetBinary = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [inputBits-1:0]  sin,
    input  logic [inputBits-1:0]  cos,
    output logic                  outValid,
    output logic [outputBits-1:0] phase,
    output logic [inputBits:0]    magnitude
);

    // Two guard bits absorb negating full scale and the ~1.647 CORDIC growth
    localparam int XW = inputBits + 2;
    localparam int IW = (iterations > 1) ? $clog2(iterations) : 1;
    localparam logic [outputBits-1:0] HALF_TURN = outputBits'(PHASE_HALF_TURN(outputBits));
    localparam logic [IW-1:0]         LAST_ITER = IW'(iterations - 1);
    localparam logic [inputBits-1:0]  MSB_FLIP  = {1'b1, {(inputBits-1){1'b0}}};

    state_t                  state;
    state_t                  nextState;
    logic signed [XW-1:0]    xReg;
    logic signed [XW-1:0]    yReg;
    logic [outputBits-1:0]   zReg;
    logic [IW-1:0]           iter;
    logic [outputBits-1:0]   atanVal;
    logic [inputBits-1:0]    cosConv;
    logic [inputBits-1:0]    sinConv;
    logic signed [XW-1:0]    cosExt;
    logic signed [XW-1:0]    sinExt;
    logic signed [XW-1:0]    xShift;
    logic signed [XW-1:0]    yShift;
    logic                    dir;
    logic                    accept;

    // Offset-binary samples become two's complement by flipping the MSB
    assign cosConv = (offsetBinary != 0) ? (cos ^ MSB_FLIP) : cos;
    assign sinConv = (offsetBinary != 0) ? (sin ^ MSB_FLIP) : sin;
    assign cosExt  = {{2{cosConv[inputBits-1]}}, cosConv};
    assign sinExt  = {{2{sinConv[inputBits-1]}}, sinConv};

    assign xShift = xReg >>> iter;
    assign yShift = yReg >>> iter;
    // Rotate clockwise while the vector is on or above the x axis
    assign dir    = ~yReg[XW-1];
    assign accept = inValid & inReady;

    sincos_atan_rom #(
        .iterations (iterations),
        .outputBits (outputBits),
        .addrBits   (IW)
    ) u_atan_rom (
        .addr    (iter),
        .atanVal (atanVal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and ready generation
    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    nextState = ROTATE;
                end
            end
            ROTATE: begin
                if (iter == LAST_ITER) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Load the quadrant-corrected sample on accept, then one micro-rotation per ROTATE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            xReg     <= '0;
            yReg     <= '0;
            zReg     <= '0;
            iter     <= '0;
            outValid <= 1'b0;
            phase    <= '0;
        end else begin
            outValid <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        iter <= '0;
                        // Left half-plane: rotate by pi so the CORDIC only sees +-90 degrees
                        if (cosExt[XW-1]) begin
                            xReg <= -cosExt;
                            yReg <= -sinExt;
                            zReg <= HALF_TURN;
                        end else begin
                            xReg <= cosExt;
                            yReg <= sinExt;
                            zReg <= '0;
                        end
                    end
                end
                ROTATE: begin
                    xReg <= dir ? (xReg + yShift) : (xReg - yShift);
                    yReg <= dir ? (yReg - xShift) : (yReg + xShift);
                    zReg <= dir ? (zReg + atanVal) : (zReg - atanVal);
                    iter <= iter + 1'b1;
                end
                DONE: begin
                    phase <= zReg;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SINCOS_MAGNITUDE_EN
    localparam int PW = XW + 17;
    logic [PW-1:0] magProduct;

    // Final x is non-negative after the pre-rotation, so an unsigned multiply is enough
    assign magProduct = PW'($unsigned(xReg)) * PW'(CORDIC_GAIN_INV_Q16);

    // Gain-compensated magnitude, captured alongside phase
    always_ff @(posedge clk) begin
        if (reset) begin
            magnitude <= '0;
        end else if (state == DONE) begin
            magnitude <= magProduct[16 +: inputBits+1];
        end
    end
`else
    assign magnitude = '0;
`endif

endmodule

// File: tb/tb_sincos_phase_detector.sv
module tb_sincos_phase_detector;

    localparam int  LATENCY = 17;
    localparam real PI_TB   = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [15:0] sinIn;
    logic [15:0] cosIn;
    logic        outValid;
    logic [15:0] phase;
    logic [16:0] magnitude;

    logic        obValid;
    logic        obReady;
    logic [15:0] obSin;
    logic [15:0] obCos;
    logic        obOutValid;
    logic [15:0] obPhase;
    logic [16:0] obMag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sincos_phase_detector #(
        .inputBits(16), .outputBits(16), .iterations(16), .offsetBinary(0)
    ) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .sin(sinIn), .cos(cosIn), .outValid(outValid), .phase(phase), .magnitude(magnitude)
    );

    sincos_phase_detector #(
        .inputBits(16), .outputBits(16), .iterations(16), .offsetBinary(1)
    ) dutOb (
        .clk(clk), .reset(reset), .inValid(obValid), .inReady(obReady),
        .sin(obSin), .cos(obCos), .outValid(obOutValid), .phase(obPhase), .magnitude(obMag)
    );

    // Ideal phase of (c, s) as an unsigned 16-bit turn fraction
    function automatic int refPhase(input int c, input int s);
        real a;
        int  p;
        a = $atan2(real'(s), real'(c));
        p = $rtoi($floor(a / (2.0 * PI_TB) * 65536.0 + 0.5));
        return ((p % 65536) + 65536) % 65536;
    endfunction

    function automatic int refMag(input int c, input int s);
        return $rtoi($floor($sqrt(real'(c) * real'(c) + real'(s) * real'(s)) + 0.5));
    endfunction

    // Circular distance between two phase codes
    function automatic int phaseDist(input logic [15:0] a, input int b);
        logic [15:0] d;
        d = a - 16'(b);
        return d[15] ? (65536 - int'(d)) : int'(d);
    endfunction

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Random sample with radius of at least half scale
    task automatic pickSample(output logic [15:0] c, output logic [15:0] s);
        int ci;
        int si;
        do begin
            c  = 16'($urandom_range(0, 65535));
            s  = 16'($urandom_range(0, 65535));
            ci = int'($signed(c));
            si = int'($signed(s));
        end while (ci * ci + si * si < 16384 * 16384);
    endtask

    // Offer one sample to either instance and wait (bounded) for its result
    task automatic runSample(input bit useOb, input logic [15:0] c, input logic [15:0] s,
                             output int latency, output logic [15:0] ph, output logic [16:0] mg);
        int w;
        w = 0;
        while (!(useOb ? obReady : inReady) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (useOb) begin
            obCos = c; obSin = s; obValid = 1'b1;
        end else begin
            cosIn = c; sinIn = s; inValid = 1'b1;
        end
        @(posedge clk); #1;
        obValid = 1'b0;
        inValid = 1'b0;
        latency = -1;
        ph = '0;
        mg = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (useOb ? obOutValid : outValid) begin
                latency = k;
                ph = useOb ? obPhase : phase;
                mg = useOb ? obMag : magnitude;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inValid = 1'b0; obValid = 1'b0;
        cosIn = '0; sinIn = '0; obCos = '0; obSin = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b want 1", inReady); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b want 0", outValid); end
        checks++; if (phase !== 16'h0) begin errors++; $display("FAIL reset_phase got %h want 0000", phase); end
        checks++; if (magnitude !== 17'h0) begin errors++; $display("FAIL reset_magnitude got %h want 0", magnitude); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Axis, quadrant and wrap-around points with phases known in closed form
    task automatic test_directed();
        logic [15:0] cv [5];
        logic [15:0] sv [5];
        int          ep [5];
        int          tol [5];
        int          lat;
        logic [15:0] ph;
        logic [16:0] mg;
        cv[0] = 16'd32767;  sv[0] = 16'd0;      ep[0] = 'h0000; tol[0] = 2;
        cv[1] = 16'd0;      sv[1] = 16'd32767;  ep[1] = 'h4000; tol[1] = 2;
        cv[2] = 16'h8000;   sv[2] = 16'd0;      ep[2] = 'h8000; tol[2] = 2;
        cv[3] = 16'd23170;  sv[3] = 16'hA57E;   ep[3] = 'hE000; tol[3] = 2;
        cv[4] = 16'd32767;  sv[4] = 16'hFFFF;   ep[4] = 'h0000; tol[4] = 1;
        for (int n = 0; n < 5; n++) begin
            runSample(1'b0, cv[n], sv[n], lat, ph, mg);
            checks++;
            if (lat != LATENCY) begin
                errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", n, lat, LATENCY);
            end
            checks++;
            if (phaseDist(ph, ep[n]) > tol[n]) begin
                errors++; $display("FAIL directed_phase[%0d] got %h want %h +-%0d", n, ph, ep[n], tol[n]);
            end
`ifdef SINCOS_MAGNITUDE_EN
            checks++;
            if (absInt(int'(mg) - refMag(int'($signed(cv[n])), int'($signed(sv[n])))) > 4) begin
                errors++; $display("FAIL directed_mag[%0d] got %0d want %0d +-4", n, mg,
                                   refMag(int'($signed(cv[n])), int'($signed(sv[n]))));
            end
`else
            checks++;
            if (mg !== 17'h0) begin
                errors++; $display("FAIL directed_mag[%0d] got %h want 0", n, mg);
            end
`endif
        end
    endtask

    // inValid held high with fresh random samples after every accept
    task automatic test_back_to_back();
        int          cQ [$];
        int          sQ [$];
        int          since;
        int          accepts;
        int          results;
        bit          readyPrev;
        logic [15:0] c;
        logic [15:0] s;
        int          ce;
        int          se;
        since = 1000; accepts = 0; results = 0;
        pickSample(c, s);
        cosIn = c; sinIn = s; inValid = 1'b1;
        readyPrev = inReady;
        for (int cyc = 0; cyc < 600 && results < 8; cyc++) begin
            @(posedge clk); #1;
            if (readyPrev && inValid) begin
                cQ.push_back(int'($signed(cosIn)));
                sQ.push_back(int'($signed(sinIn)));
                accepts++;
                since = 0;
                if (accepts < 8) begin
                    pickSample(c, s);
                    cosIn = c; sinIn = s;
                end else begin
                    inValid = 1'b0;
                end
            end else begin
                since++;
            end
            checks++;
            if (inReady !== (since >= LATENCY)) begin
                errors++; $display("FAIL b2b_inReady cycle %0d since accept got %b want %b", since, inReady, since >= LATENCY);
            end
            checks++;
            if (outValid !== (since == LATENCY)) begin
                errors++; $display("FAIL b2b_outValid cycle %0d since accept got %b want %b", since, outValid, since == LATENCY);
            end
            if (outValid === 1'b1) begin
                checks++;
                if (cQ.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_result got phase %h want no result", phase);
                end else begin
                    ce = cQ.pop_front();
                    se = sQ.pop_front();
                    results++;
                    if (phaseDist(phase, refPhase(ce, se)) > 3) begin
                        errors++; $display("FAIL b2b_phase (%0d,%0d) got %h want %h +-3", ce, se, phase, refPhase(ce, se));
                    end
                end
            end
            readyPrev = inReady;
        end
        inValid = 1'b0;
        checks++;
        if (results != 8 || cQ.size() != 0) begin
            errors++; $display("FAIL b2b_count got %0d results %0d pending want 8 and 0", results, cQ.size());
        end
    endtask

    // Reset during ROTATE aborts the sample; the next one completes normally
    task automatic test_reset_midop();
        int          lat;
        logic [15:0] ph;
        logic [16:0] mg;
        int          spurious;
        runSample(1'b0, 16'd0, 16'd32767, lat, ph, mg);
        cosIn = 16'd12000; sinIn = 16'd20000; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL midreset_inReady got %b want 1", inReady); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midreset_outValid got %b want 0", outValid); end
        checks++; if (phase !== 16'h0) begin errors++; $display("FAIL midreset_phase got %h want 0000", phase); end
        reset = 1'b0;
        spurious = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (outValid === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL midreset_aborted got %0d pulses want 0", spurious); end
        runSample(1'b0, 16'hB000, 16'd9000, lat, ph, mg);
        checks++;
        if (lat != LATENCY) begin errors++; $display("FAIL midreset_latency got %0d want %0d", lat, LATENCY); end
        checks++;
        if (phaseDist(ph, refPhase(-20480, 9000)) > 2) begin
            errors++; $display("FAIL midreset_phase_after got %h want %h +-2", ph, refPhase(-20480, 9000));
        end
    endtask

    // Offset-binary loopback from an ideal NCO over the whole circle
    task automatic test_loopback();
        int          lat;
        logic [15:0] ph;
        logic [16:0] mg;
        real         theta;
        int          cs;
        int          sn;
        for (int p = 0; p < 65536; p += 257) begin
            theta = 2.0 * PI_TB * real'(p) / 65536.0;
            cs = $rtoi($floor(32767.0 * $cos(theta) + 0.5)) + 32768;
            sn = $rtoi($floor(32767.0 * $sin(theta) + 0.5)) + 32768;
            runSample(1'b1, 16'(cs), 16'(sn), lat, ph, mg);
            checks++;
            if (lat != LATENCY || phaseDist(ph, p) > 8) begin
                errors++; $display("FAIL loopback drive %h got %h latency %0d want +-8 latency %0d", p, ph, lat, LATENCY);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midop();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
